// File: rtl/instruction_fetch_if.sv
// Instruction-memory fetch handshake: req/addr from the fetch stage, ack/rdata from memory.
// ack may arrive in the same cycle as req, and rdata is only meaningful while ack is high.
interface instruction_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instruction_fetch.sv
// Pipeline front end: owns the PC, fetches words over a req/ack handshake and drives IF/ID.
// Honours hazard freeze and execute-stage branch redirects; tolerates variable memory latency.
//
//   state | meaning
//   FETCH | request outstanding at fetch_addr_q
//   STALL | word fetched under freeze, parked in skid buffer, no request
//   DRAIN | outstanding request must complete and be discarded, then jump to pend_addr_q
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] BUBBLE   = 32'hE1A0_0000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       freeze_i,
  input  logic                       branch_taken_i,
  input  logic [31:0]                branch_address_i,
  instruction_fetch_if.master        imem_if,
  output logic [31:0]                instruction_o,
  output logic [31:0]                pc_out_o,
  output logic                       if_valid_o
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [31:0] skid_word_q, skid_word_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  logic        req;
  logic        ack_seen;
  logic [31:0] br_target;
  logic [31:0] fetch_addr_inc;

  assign req            = (state_q != STALL);
  assign ack_seen       = req && imem_if.ack;
  assign br_target      = {branch_address_i[31:2], 2'b00};
  assign fetch_addr_inc = fetch_addr_q + 32'd4;

  assign imem_if.req  = req;
  assign imem_if.addr = fetch_addr_q;

  assign instruction_o = instr_q;
  assign pc_out_o      = pc_q;
  assign if_valid_o    = valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= FETCH;
      fetch_addr_q <= RESET_PC;
      pend_addr_q  <= 32'd0;
      skid_word_q  <= 32'd0;
      instr_q      <= BUBBLE;
      pc_q         <= 32'd0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      pend_addr_q  <= pend_addr_d;
      skid_word_q  <= skid_word_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    pend_addr_d  = pend_addr_q;
    skid_word_d  = skid_word_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    valid_d      = valid_q;

    if (branch_taken_i) begin
      // Redirect beats freeze and ack; pc_out is left as-is under the bubble.
      instr_d = BUBBLE;
      valid_d = 1'b0;
      if (state_q == STALL || ack_seen) begin
        fetch_addr_d = br_target;
        state_d      = FETCH;
      end else begin
        pend_addr_d = br_target;
        state_d     = DRAIN;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (ack_seen && freeze_i) begin
            skid_word_d = imem_if.rdata;
            state_d     = STALL;
          end else if (ack_seen) begin
            instr_d      = imem_if.rdata;
            pc_d         = fetch_addr_inc;
            valid_d      = 1'b1;
            fetch_addr_d = fetch_addr_inc;
          end else if (!freeze_i) begin
            instr_d = BUBBLE;
            valid_d = 1'b0;
          end
        end
        STALL: begin
          if (!freeze_i) begin
            instr_d      = skid_word_q;
            pc_d         = fetch_addr_inc;
            valid_d      = 1'b1;
            fetch_addr_d = fetch_addr_inc;
            state_d      = FETCH;
          end
        end
        DRAIN: begin
          if (ack_seen) begin
            fetch_addr_d = pend_addr_q;
            state_d      = FETCH;
          end
          if (!freeze_i) begin
            instr_d = BUBBLE;
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front end of the five-stage ARM pipeline. Owns the program counter, issues word fetches to instruction memory over a req/ack handshake, and drives the IF/ID pipeline register consumed by the decode stage (`instruction`, `pc_out`). Honours the hazard unit's freeze and the execute stage's branch redirect, and tolerates a variable-latency memory.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `BUBBLE`, 32'hE1A0_0000 (MOV r0,r0), instruction word presented when no valid instruction is available
- `clk` in 1, single clock, all state updates on rising edge
- `rst` in 1, reset, synchronous, active-high
- `freeze` in 1, hazard stall from the hazard unit; hold IF/ID and PC
- `branch_taken` in 1, redirect request from execute; flushes IF/ID
- `branch_address` in 32, redirect target, sampled when `branch_taken`=1
- `imem_req` out 1, fetch request
- `imem_addr` out 32, word-aligned fetch address
- `imem_ack` in 1, memory has returned `imem_rdata` this cycle (may be same cycle as req)
- `imem_rdata` in 32, fetched word, valid only when `imem_ack`=1
- `instruction` out 32, IF/ID instruction to decode
- `pc_out` out 32, IF/ID PC (fetch address + 4)
- `if_valid` out 1, IF/ID holds a real instruction (0 = bubble)

## Operation
- Registers: `fetch_addr` (drives `imem_addr`), `pend_addr`, skid buffer `skid_word`, IF/ID {`instruction`,`pc_out`,`if_valid`}, 2-bit state.
- States: FETCH (`imem_req`=1), STALL (`imem_req`=0, fetched word in skid), DRAIN (`imem_req`=1, outstanding fetch to be discarded). `imem_req` decoded from state only.
- Handshake: once `imem_req`=1, `imem_addr` stays constant until the cycle `imem_ack`=1. `imem_ack` outside a request is ignored.
- FETCH, ack, no freeze, no branch: IF/ID <= {rdata, fetch_addr+4, 1}; fetch_addr += 4; stay FETCH (back-to-back requests).
- FETCH, no ack, no freeze, no branch: IF/ID <= {BUBBLE, pc_out unchanged, 0}; hold.
- FETCH, ack, freeze: IF/ID holds; skid_word <= rdata; go STALL.
- FETCH, no ack, freeze: IF/ID holds; hold.
- STALL, freeze: hold everything. STALL, !freeze: IF/ID <= {skid_word, fetch_addr+4, 1}; fetch_addr += 4; go FETCH.
- Branch (priority over freeze and ack, any state): IF/ID <= {BUBBLE, pc_out unchanged, 0}.
  - FETCH with ack, or STALL: fetch_addr <= branch_address; skid discarded; go/stay FETCH.
  - FETCH without ack: pend_addr <= branch_address; go DRAIN.
  - DRAIN: pend_addr <= branch_address (latest wins).
- DRAIN without branch: on ack, discard rdata, fetch_addr <= pend_addr, go FETCH; IF/ID <= bubble unless freeze (freeze holds the bubble).
- Address arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. `branch_address[1:0]` forced to 0.

## Timing
- Reset (rst=1 at edge): state=FETCH, fetch_addr=RESET_PC, pend_addr=0, skid_word=0, instruction=BUBBLE, pc_out=0, if_valid=0. So after reset `imem_req`=1, `imem_addr`=RESET_PC. Reset mid-request abandons it; memory shares `rst`.
- Zero-wait memory (ack tied 1): one instruction per cycle; word at A appears on `instruction` one cycle after the edge sampling its ack.
- Branch sampled at edge N (ack same cycle): `imem_addr`=target during cycle N+1; target instruction on IF/ID after edge N+1; exactly one bubble.
- Branch with outstanding request: target issued the cycle after the draining ack.
- Freeze latency 0: IF/ID unchanged at any edge where freeze=1 and branch_taken=0.

## Test plan
- Reset, ack tied 1, RESET_PC=0, imem_rdata=addr-tagged words: IF/ID shows words for 0,4,8,… on consecutive cycles, pc_out=4,8,12,…, if_valid=1.
- Ack every 3rd cycle of a request: addr stable while req high; if_valid=0 with BUBBLE between fetches; no word lost or duplicated.
- Freeze 4 cycles while ack arrives for 0x10: IF/ID holds prior word, req low in STALL; on release IF/ID = word@0x10, pc_out=0x14, next req 0x14.
- branch_taken with branch_address=0x100 while request to 0x20 pending 2 cycles: req stays at 0x20 until ack, word discarded, next req 0x100, IF/ID = word@0x100, pc_out=0x104.
- branch_taken and freeze same cycle in STALL: IF/ID flushed to BUBBLE/if_valid=0, skid dropped, next req = branch_address.
- rst asserted mid-request to 0x40: next cycle imem_addr=RESET_PC, req=1, instruction=BUBBLE, if_valid=0, pc_out=0.
